// File: rtl/issue_stage_buffer.sv
// issue_stage_buffer
// Decode-to-execute pipeline register for the MZNM pipeline. It holds the
// decoded control bundle, operands and register addresses for the ALU. It
// adds stall hold, two-word (immediate-carrying) instruction assembly,
// counted post-branch flush bubbles and an external redirect kill.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             freeze all state and outputs for this cycle
//   redirect          kill held/flushing state, issue a bubble (beats stall)
//   in_valid          decode slot holds a word
//   in_instr          raw word; the immediate while waiting for a second word
//   in_ctrl           opaque decoded control bundle
//   in_two_word       instruction takes the following word as its immediate
//   in_flush_num      bubbles to insert after this instruction issues
//   in_rs_data/in_rt_data, in_rd_addr/in_rs_addr, in_imm_small  operands
//   out_*             registered execute-slot contents (out_ctrl zero on bubble)
//   out_imm_word      captured second word, zero for one-word instructions
//   busy              first word of a two-word instruction is being held
//   perf_bubbles      saturating bubble counter
//
// Build option
//   ISSUE_BUBBLE_CNT_EN  when defined, perf_bubbles counts issued bubbles;
//                        otherwise it is tied to zero.
module issue_stage_buffer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int CTRL_W  = 16,
  parameter int FLUSH_W = 2,
  parameter int IMM_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_two_word,
  input  logic [FLUSH_W-1:0] in_flush_num,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [ADDR_W-1:0] in_rd_addr,
  input  logic [ADDR_W-1:0] in_rs_addr,
  input  logic [IMM_W-1:0]  in_imm_small,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [ADDR_W-1:0] out_rd_addr,
  output logic [ADDR_W-1:0] out_rs_addr,
  output logic [IMM_W-1:0]  out_imm_small,
  output logic [DATA_W-1:0] out_imm_word,
  output logic              busy,
  output logic [15:0]       perf_bubbles
);

  typedef enum logic [1:0] {ISSUE, WAIT_IMM, FLUSH} state_t;

  state_t              stateReg;
  logic [FLUSH_W-1:0]  flushCntReg;

  // First word of a two-word instruction, parked until its immediate arrives.
  logic [CTRL_W-1:0]   holdCtrlReg;
  logic [DATA_W-1:0]   holdRsDataReg;
  logic [DATA_W-1:0]   holdRtDataReg;
  logic [ADDR_W-1:0]   holdRdAddrReg;
  logic [ADDR_W-1:0]   holdRsAddrReg;
  logic [IMM_W-1:0]    holdImmSmallReg;
  logic [FLUSH_W-1:0]  holdFlushReg;

  assign busy = (stateReg == WAIT_IMM);

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg        <= ISSUE;
      flushCntReg     <= '0;
      holdCtrlReg     <= '0;
      holdRsDataReg   <= '0;
      holdRtDataReg   <= '0;
      holdRdAddrReg   <= '0;
      holdRsAddrReg   <= '0;
      holdImmSmallReg <= '0;
      holdFlushReg    <= '0;
      out_valid       <= 1'b0;
      out_ctrl        <= '0;
      out_rs_data     <= '0;
      out_rt_data     <= '0;
      out_rd_addr     <= '0;
      out_rs_addr     <= '0;
      out_imm_small   <= '0;
      out_imm_word    <= '0;
    end else if (redirect) begin
      // Leaving WAIT_IMM is what invalidates the hold register.
      stateReg    <= ISSUE;
      flushCntReg <= '0;
      out_valid   <= 1'b0;
      out_ctrl    <= '0;
    end else if (!stall) begin
      case (stateReg)
        ISSUE: begin
          if (in_valid && !in_two_word) begin
            out_valid     <= 1'b1;
            out_ctrl      <= in_ctrl;
            out_rs_data   <= in_rs_data;
            out_rt_data   <= in_rt_data;
            out_rd_addr   <= in_rd_addr;
            out_rs_addr   <= in_rs_addr;
            out_imm_small <= in_imm_small;
            out_imm_word  <= '0;
            if (in_flush_num != '0) begin
              flushCntReg <= in_flush_num;
              stateReg    <= FLUSH;
            end
          end else begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            if (in_valid) begin
              holdCtrlReg     <= in_ctrl;
              holdRsDataReg   <= in_rs_data;
              holdRtDataReg   <= in_rt_data;
              holdRdAddrReg   <= in_rd_addr;
              holdRsAddrReg   <= in_rs_addr;
              holdImmSmallReg <= in_imm_small;
              holdFlushReg    <= in_flush_num;
              stateReg        <= WAIT_IMM;
            end
          end
        end
        WAIT_IMM: begin
          if (in_valid) begin
            // Only in_instr matters here; the decode side fields belong to
            // the immediate word and are meaningless.
            out_valid     <= 1'b1;
            out_ctrl      <= holdCtrlReg;
            out_rs_data   <= holdRsDataReg;
            out_rt_data   <= holdRtDataReg;
            out_rd_addr   <= holdRdAddrReg;
            out_rs_addr   <= holdRsAddrReg;
            out_imm_small <= holdImmSmallReg;
            out_imm_word  <= in_instr;
            if (holdFlushReg != '0) begin
              flushCntReg <= holdFlushReg;
              stateReg    <= FLUSH;
            end else begin
              stateReg <= ISSUE;
            end
          end else begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
          end
        end
        FLUSH: begin
          out_valid <= 1'b0;
          out_ctrl  <= '0;
          if (flushCntReg != '0) begin
            flushCntReg <= flushCntReg - FLUSH_W'(1);
          end
          // A zero count cannot normally occur here; treat it as done.
          if (flushCntReg <= FLUSH_W'(1)) begin
            stateReg <= ISSUE;
          end
        end
        default: begin
          stateReg  <= ISSUE;
          out_valid <= 1'b0;
          out_ctrl  <= '0;
        end
      endcase
    end
  end

`ifdef ISSUE_BUBBLE_CNT_EN
  logic [15:0] bubbleCntReg;
  logic        outUpdate;
  logic        issueNow;

  // The output register is rewritten on any non-stalled cycle, and on a
  // redirect even when stalled; it carries a real instruction only here.
  always_comb begin
    outUpdate = 1'b0;
    issueNow  = 1'b0;
    outUpdate = redirect || !stall;
    issueNow  = !redirect && !stall && in_valid &&
                ((stateReg == ISSUE && !in_two_word) || stateReg == WAIT_IMM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubbleCntReg <= '0;
    end else if (outUpdate && !issueNow && bubbleCntReg != 16'hFFFF) begin
      bubbleCntReg <= bubbleCntReg + 16'd1;
    end
  end

  assign perf_bubbles = bubbleCntReg;
`else
  assign perf_bubbles = 16'h0000;
`endif

endmodule

// File: tb/tb_issue_stage_buffer.sv
// tb_issue_stage_buffer
// Directed bench for issue_stage_buffer. The stimulus process pushes the
// expected execute-slot contents for every instruction that should issue;
// a monitor pops and compares each time the DUT presents a newly issued
// instruction. Cycle-level checks (bubbles, busy, reset, counter) are made
// inline by the stimulus process.
module tb_issue_stage_buffer;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [15:0] rsData;
    logic [15:0] rtData;
    logic [2:0]  rdAddr;
    logic [2:0]  rsAddr;
    logic [4:0]  immSmall;
    logic [15:0] immWord;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [15:0] in_ctrl;
  logic        in_two_word;
  logic [1:0]  in_flush_num;
  logic [15:0] in_rs_data;
  logic [15:0] in_rt_data;
  logic [2:0]  in_rd_addr;
  logic [2:0]  in_rs_addr;
  logic [4:0]  in_imm_small;
  logic        out_valid;
  logic [15:0] out_ctrl;
  logic [15:0] out_rs_data;
  logic [15:0] out_rt_data;
  logic [2:0]  out_rd_addr;
  logic [2:0]  out_rs_addr;
  logic [4:0]  out_imm_small;
  logic [15:0] out_imm_word;
  logic        busy;
  logic [15:0] perf_bubbles;

  int   nChecks = 0;
  int   nFails  = 0;
  int   txnNum  = 0;
  exp_t expQ[$];
  logic updEdge = 1'b0;

  issue_stage_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ctrl      (in_ctrl),
    .in_two_word  (in_two_word),
    .in_flush_num (in_flush_num),
    .in_rs_data   (in_rs_data),
    .in_rt_data   (in_rt_data),
    .in_rd_addr   (in_rd_addr),
    .in_rs_addr   (in_rs_addr),
    .in_imm_small (in_imm_small),
    .out_valid    (out_valid),
    .out_ctrl     (out_ctrl),
    .out_rs_data  (out_rs_data),
    .out_rt_data  (out_rt_data),
    .out_rd_addr  (out_rd_addr),
    .out_rs_addr  (out_rs_addr),
    .out_imm_small(out_imm_small),
    .out_imm_word (out_imm_word),
    .busy         (busy),
    .perf_bubbles (perf_bubbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The output register takes a new value on this edge unless reset or a
  // plain stall (without redirect) is applied.
  always @(posedge clk) updEdge = !reset && (!stall || redirect);

  // Monitor: one popped expectation per newly issued instruction.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (updEdge && out_valid) begin
      got = {out_ctrl, out_rs_data, out_rt_data, out_rd_addr, out_rs_addr,
             out_imm_small, out_imm_word};
      nChecks++;
      txnNum++;
      if (expQ.size() == 0) begin
        nFails++;
        $display("FAIL unexpected_issue txn %0d: got ctrl=%h, required no issue", txnNum, out_ctrl);
      end else begin
        want = expQ.pop_front();
        if (got !== want) begin
          nFails++;
          $display("FAIL issue_txn %0d: got %h, required %h", txnNum, got, want);
        end else begin
          $display("txn %0d issued ctrl=%h rd=%0d imm_word=%h", txnNum, out_ctrl, out_rd_addr, out_imm_word);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic pushE(input logic [15:0] c, input logic [15:0] rs, input logic [15:0] rt,
                       input logic [2:0] rd, input logic [2:0] rsa, input logic [4:0] imm,
                       input logic [15:0] iw);
    expQ.push_back({c, rs, rt, rd, rsa, imm, iw});
  endtask

  task automatic send(input logic v, input logic [15:0] instr, input logic [15:0] c,
                      input logic two, input logic [1:0] fl, input logic [15:0] rs,
                      input logic [15:0] rt, input logic [2:0] rd, input logic [2:0] rsa,
                      input logic [4:0] imm);
    in_valid     = v;
    in_instr     = instr;
    in_ctrl      = c;
    in_two_word  = two;
    in_flush_num = fl;
    in_rs_data   = rs;
    in_rt_data   = rt;
    in_rd_addr   = rd;
    in_rs_addr   = rsa;
    in_imm_small = imm;
    tick();
  endtask

  task automatic idle();
    send(1'b0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 16'h0, 3'd0, 3'd0, 5'd0);
  endtask

  initial begin
    logic [15:0] perfReq;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0;

    // Reset with a live input must not leak anything onto the outputs.
    send(1'b1, 16'h1111, 16'h00FF, 1'b0, 2'd1, 16'hAAAA, 16'h5555, 3'd7, 3'd7, 5'd31);
    send(1'b1, 16'h1111, 16'h00FF, 1'b0, 2'd1, 16'hAAAA, 16'h5555, 3'd7, 3'd7, 5'd31);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_rs_data", out_rs_data, 0);
    chk("rst_out_rd_addr", out_rd_addr, 0);
    chk("rst_out_imm_word", out_imm_word, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perf", perf_bubbles, 0);
    reset = 1'b0;

    // Three back-to-back one-word instructions.
    pushE(16'h0011, 16'h0101, 16'h0202, 3'd1, 3'd2, 5'd5, 16'h0);
    send(1'b1, 16'h9000, 16'h0011, 1'b0, 2'd0, 16'h0101, 16'h0202, 3'd1, 3'd2, 5'd5);
    chk("one_word_a_valid", out_valid, 1);
    pushE(16'h0022, 16'h0303, 16'h0404, 3'd2, 3'd3, 5'd6, 16'h0);
    send(1'b1, 16'h9001, 16'h0022, 1'b0, 2'd0, 16'h0303, 16'h0404, 3'd2, 3'd3, 5'd6);
    chk("one_word_b_valid", out_valid, 1);
    pushE(16'h0033, 16'h0505, 16'h0606, 3'd4, 3'd5, 5'd7, 16'h0);
    send(1'b1, 16'h9002, 16'h0033, 1'b0, 2'd0, 16'h0505, 16'h0606, 3'd4, 3'd5, 5'd7);
    chk("one_word_c_valid", out_valid, 1);
    idle();
    chk("idle_valid", out_valid, 0);
    chk("idle_ctrl", out_ctrl, 0);

    // Two-word LDM, immediate arrives after two idle cycles.
    send(1'b1, 16'h0, 16'h00A5, 1'b1, 2'd0, 16'h0A0A, 16'h0B0B, 3'd3, 3'd1, 5'd9);
    chk("ldm_busy1", busy, 1);
    chk("ldm_bubble1", out_valid, 0);
    chk("ldm_bubble1_ctrl", out_ctrl, 0);
    idle();
    chk("ldm_busy2", busy, 1);
    idle();
    chk("ldm_busy3", busy, 1);
    chk("ldm_bubble3", out_valid, 0);
    pushE(16'h00A5, 16'h0A0A, 16'h0B0B, 3'd3, 3'd1, 5'd9, 16'hBEEF);
    send(1'b1, 16'hBEEF, 16'hFFFF, 1'b1, 2'd3, 16'hDEAD, 16'hDEAD, 3'd7, 3'd7, 5'd31);
    chk("ldm_issue_valid", out_valid, 1);
    chk("ldm_issue_busy", busy, 0);
    chk("ldm_rd_addr", out_rd_addr, 3);
    chk("ldm_imm_word", out_imm_word, 16'hBEEF);
    // The flush field on the immediate word is ignored: next issues at once.
    pushE(16'h0044, 16'h0C0C, 16'h0D0D, 3'd6, 3'd4, 5'd2, 16'h0);
    send(1'b1, 16'h0, 16'h0044, 1'b0, 2'd0, 16'h0C0C, 16'h0D0D, 3'd6, 3'd4, 5'd2);
    chk("after_ldm_valid", out_valid, 1);
    chk("after_ldm_imm_word", out_imm_word, 0);

    // Branch with flush of 2; X, Y discarded, one stall after X, Z issues.
    pushE(16'h00B2, 16'h1111, 16'h2222, 3'd0, 3'd0, 5'd0, 16'h0);
    send(1'b1, 16'h0, 16'h00B2, 1'b0, 2'd2, 16'h1111, 16'h2222, 3'd0, 3'd0, 5'd0);
    chk("branch_valid", out_valid, 1);
    send(1'b1, 16'h0, 16'h00E1, 1'b0, 2'd0, 16'hE1E1, 16'hE1E1, 3'd1, 3'd1, 5'd1);
    chk("flush_bubble1", out_valid, 0);
    chk("flush_bubble1_ctrl", out_ctrl, 0);
    stall = 1'b1;
    send(1'b1, 16'h0, 16'h00E2, 1'b0, 2'd0, 16'hE2E2, 16'hE2E2, 3'd2, 3'd2, 5'd2);
    chk("flush_stall_hold", out_valid, 0);
    stall = 1'b0;
    send(1'b1, 16'h0, 16'h00E2, 1'b0, 2'd0, 16'hE2E2, 16'hE2E2, 3'd2, 3'd2, 5'd2);
    chk("flush_bubble2", out_valid, 0);
    pushE(16'h00E3, 16'h3333, 16'h4444, 3'd5, 3'd6, 5'd3, 16'h0);
    send(1'b1, 16'h0, 16'h00E3, 1'b0, 2'd0, 16'h3333, 16'h4444, 3'd5, 3'd6, 5'd3);
    chk("z_issue_valid", out_valid, 1);
    chk("z_issue_ctrl", out_ctrl, 16'h00E3);

    // Stall holds a valid output unchanged.
    stall = 1'b1;
    send(1'b1, 16'h0, 16'h00F0, 1'b0, 2'd0, 16'h5555, 16'h6666, 3'd1, 3'd1, 5'd1);
    chk("stall_hold_valid", out_valid, 1);
    chk("stall_hold_ctrl", out_ctrl, 16'h00E3);
    stall = 1'b0;
    pushE(16'h00F0, 16'h5555, 16'h6666, 3'd1, 3'd1, 5'd1, 16'h0);
    send(1'b1, 16'h0, 16'h00F0, 1'b0, 2'd0, 16'h5555, 16'h6666, 3'd1, 3'd1, 5'd1);
    idle();

    // Stall and redirect together while waiting for an immediate.
    send(1'b1, 16'h0, 16'h00C7, 1'b1, 2'd1, 16'h7777, 16'h8888, 3'd2, 3'd3, 5'd4);
    chk("redir_pre_busy", busy, 1);
    stall = 1'b1; redirect = 1'b1;
    send(1'b1, 16'h1234, 16'h00C8, 1'b0, 2'd0, 16'h0, 16'h0, 3'd0, 3'd0, 5'd0);
    chk("redir_busy", busy, 0);
    chk("redir_valid", out_valid, 0);
    chk("redir_ctrl", out_ctrl, 0);
    stall = 1'b0; redirect = 1'b0;
    pushE(16'h0055, 16'h9999, 16'hAAAA, 3'd7, 3'd6, 5'd8, 16'h0);
    send(1'b1, 16'h0, 16'h0055, 1'b0, 2'd0, 16'h9999, 16'hAAAA, 3'd7, 3'd6, 5'd8);
    chk("redir_next_valid", out_valid, 1);

    // Reset in FLUSH with a count of 3 discards the remaining bubbles.
    pushE(16'h00B3, 16'hBBBB, 16'hCCCC, 3'd1, 3'd2, 5'd3, 16'h0);
    send(1'b1, 16'h0, 16'h00B3, 1'b0, 2'd3, 16'hBBBB, 16'hCCCC, 3'd1, 3'd2, 5'd3);
    chk("flush3_branch_valid", out_valid, 1);
    reset = 1'b1;
    idle();
    chk("flush3_reset_valid", out_valid, 0);
    reset = 1'b0;
    pushE(16'h0066, 16'hDDDD, 16'hEEEE, 3'd4, 3'd5, 5'd6, 16'h0);
    send(1'b1, 16'h0, 16'h0066, 1'b0, 2'd0, 16'hDDDD, 16'hEEEE, 3'd4, 3'd5, 5'd6);
    chk("post_reset_issue", out_valid, 1);
    chk("post_reset_ctrl", out_ctrl, 16'h0066);

    // Bubble counter: five idle cycles after reset.
    reset = 1'b1;
    idle();
    chk("perf_after_reset", perf_bubbles, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) idle();
`ifdef ISSUE_BUBBLE_CNT_EN
    perfReq = 16'd5;
`else
    perfReq = 16'd0;
`endif
    chk("perf_five_idle", perf_bubbles, perfReq);

    idle();
    chk("queue_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
